// File: rtl/q_capture_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// q_pkg
//   Shared definitions for the resolver-bank capture controller:
//   - FSM state encodings for q_capture_ctrl
//   - dual-rail lane codes as seen after synchronisation, written {rh_l, rl_l}
//   - a helper that maps a legal resolved code to its data bit
// ---------------------------------------------------------------------------
package q_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Both rails are active low, so a lane that has not settled reads 11.
  localparam logic [1:0] DR_NONE = 2'b11;
  localparam logic [1:0] DR_HI   = 2'b01;
  localparam logic [1:0] DR_LO   = 2'b10;
  localparam logic [1:0] DR_BAD  = 2'b00;

  // Data bit for one lane. Only meaningful for DR_HI/DR_LO; the caller
  // screens out DR_NONE and DR_BAD before the word is used.
  function automatic logic lane_value(input logic [1:0] code);
    logic v;
    case (code)
      DR_HI:   v = 1'b1;
      DR_LO:   v = 1'b0;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/q_dr_sync.sv
// ---------------------------------------------------------------------------
// q_dr_sync
//   Multi-flop synchroniser for WIDTH dual-rail lanes coming from the
//   asynchronous resolver bank. Each rail bit gets its own SYNC_STAGES chain.
//   Ports:
//     clk, rst         clock and synchronous active-high reset
//     rh_l, rl_l       asynchronous active-low rails from the resolvers
//     rh_l_s, rl_l_s   synchronised rails
//   Every flop resets to 1 so a freshly reset chain reads as "unresolved"
//   rather than as the illegal 00 code.
// ---------------------------------------------------------------------------
module q_dr_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rh_l,
  input  logic [WIDTH-1:0] rl_l,
  output logic [WIDTH-1:0] rh_l_s,
  output logic [WIDTH-1:0] rl_l_s
);

  logic [WIDTH-1:0] rh_pipe [SYNC_STAGES];
  logic [WIDTH-1:0] rl_pipe [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        rh_pipe[s] <= '1;
        rl_pipe[s] <= '1;
      end
    end else begin
      rh_pipe[0] <= rh_l;
      rl_pipe[0] <= rl_l;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        rh_pipe[s] <= rh_pipe[s-1];
        rl_pipe[s] <= rl_pipe[s-1];
      end
    end
  end

  assign rh_l_s = rh_pipe[SYNC_STAGES-1];
  assign rl_l_s = rl_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/q_capture_ctrl.sv
// ---------------------------------------------------------------------------
// q_capture_ctrl
//   Strobes a bank of q_resolver lanes, waits for every lane to resolve and
//   hands the packed word downstream over valid/ready. Illegal lane codes and
//   lanes that never settle raise sticky error flags instead of a word.
//   Ports:
//     clk, rst               clock and synchronous active-high reset
//     start                  capture request, honoured only in IDLE
//     q_rst, q_clk           reset and sample strobe to the resolver bank
//     rh_l, rl_l             asynchronous active-low dual-rail lane outputs
//     out_data, out_valid    captured word and its valid (held until accepted)
//     out_ready              downstream accept
//     busy                   high in every state except IDLE
//     err_both, err_timeout  sticky errors, cleared by the next accepted start
// ---------------------------------------------------------------------------
module q_capture_ctrl
  import q_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             q_rst,
  output logic             q_clk,
  input  logic [WIDTH-1:0] rh_l,
  input  logic [WIDTH-1:0] rl_l,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err_both,
  output logic             err_timeout
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_EVAL = CNT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_TMO  = CNT_W'(TIMEOUT);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rh_l_s;
  logic [WIDTH-1:0] rl_l_s;
  logic [WIDTH-1:0] lane_word;
  logic             any_bad;
  logic             all_resolved;
  logic             eval;

  q_dr_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .rh_l   (rh_l),
    .rl_l   (rl_l),
    .rh_l_s (rh_l_s),
    .rl_l_s (rl_l_s)
  );

  // Decode every lane. lane_word is only used when no lane is bad and none
  // is still unresolved, so its value for those codes does not matter.
  always_comb begin
    any_bad      = 1'b0;
    all_resolved = 1'b1;
    lane_word    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if ({rh_l_s[i], rl_l_s[i]} == DR_BAD)  any_bad      = 1'b1;
      if ({rh_l_s[i], rl_l_s[i]} == DR_NONE) all_resolved = 1'b0;
      lane_word[i] = lane_value({rh_l_s[i], rl_l_s[i]});
    end
  end

  // The first SYNC_STAGES WAIT cycles still carry pre-strobe values in the
  // synchroniser, so lanes are not looked at until they have been flushed.
  assign eval = (cnt >= CNT_EVAL);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_ARM;
      ST_ARM:  state_nx = ST_WAIT;
      ST_WAIT: begin
        if (eval) begin
          if (any_bad)           state_nx = ST_IDLE;
          else if (all_resolved) state_nx = ST_HOLD;
          else if (cnt == CNT_TMO) state_nx = ST_IDLE;
        end
      end
      ST_HOLD: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so q_clk/q_rst reach the
  // resolver bank glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      out_data    <= '0;
      err_both    <= 1'b0;
      err_timeout <= 1'b0;
      q_rst       <= 1'b1;
      q_clk       <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state     <= state_nx;
      q_rst     <= (state_nx == ST_IDLE) || (state_nx == ST_HOLD);
      q_clk     <= (state_nx == ST_ARM);
      out_valid <= (state_nx == ST_HOLD);
      busy      <= (state_nx != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_both    <= 1'b0;
            err_timeout <= 1'b0;
          end
        end
        ST_ARM: cnt <= '0;
        ST_WAIT: begin
          if (cnt != CNT_TMO) cnt <= cnt + 1'b1;
          if (eval) begin
            if (any_bad)             err_both    <= 1'b1;
            else if (all_resolved)   out_data    <= lane_word;
            else if (cnt == CNT_TMO) err_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
